color_scan_ctrl: RTL

COLOR_SCAN_CTRL -- requirements
Module: color_scan_ctrl

---
 rtl/color_scan_ctrl_pkg.sv | 33 +++
 rtl/color_max_select.sv | 28 ++
 rtl/color_scan_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/color_scan_ctrl_pkg.sv
// Shared definitions for the color scan controller and the color tracker it drives:
// color codes, FSM encoding and default parameter values.
package color_scan_ctrl_pkg;

    localparam logic [1:0] ColorR = 2'b00;
    localparam logic [1:0] ColorG = 2'b01;
    localparam logic [1:0] ColorB = 2'b10;

    localparam int unsigned DefCountWidth   = 19;
    localparam int unsigned DefSettleCycles = 3;
    localparam int unsigned DefDrainCycles  = 2;
    localparam int unsigned DefMinCount     = 64;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StActive,
        StDrain,
        StReport
    } scan_state_e;

    // Round-robin order R -> G -> B -> R.
    function automatic logic [1:0] next_color(input logic [1:0] color);
        logic [1:0] nxt;
        unique case (color)
            ColorR:  nxt = ColorG;
            ColorG:  nxt = ColorB;
            default: nxt = ColorR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/color_max_select.sv
// Picks the largest of three per-color counts; on a tie the lowest color index wins.
module color_max_select
    import color_scan_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefCountWidth
) (
    input  logic [WIDTH-1:0] count_r,
    input  logic [WIDTH-1:0] count_g,
    input  logic [WIDTH-1:0] count_b,
    output logic [1:0]       max_idx,
    output logic [WIDTH-1:0] max_val
);

    // Strict greater-than keeps the earlier (lower) index on ties.
    always_comb begin
        max_idx = ColorR;
        max_val = count_r;
        if (count_g > max_val) begin
            max_idx = ColorG;
            max_val = count_g;
        end
        if (count_b > max_val) begin
            max_idx = ColorB;
            max_val = count_b;
        end
    end

endmodule

// File: rtl/color_scan_ctrl.sv
// Per-frame target-pixel counter that steers the color tracker, in fixed or R/G/B
// round-robin mode, and keeps the best color found over the last full scan.
module color_scan_ctrl
    import color_scan_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = DefCountWidth,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
    parameter int unsigned DRAIN_CYCLES  = DefDrainCycles,
    parameter int unsigned MIN_COUNT     = DefMinCount
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   scan_mode,
    input  logic [1:0]             fixed_color,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic                   trk_valid,
    input  logic                   trk_is_target,
    output logic [1:0]             color_select,
    output logic                   busy,
    output logic                   result_valid,
    output logic [1:0]             result_color,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic                   best_valid,
    output logic [1:0]             best_color,
    output logic [COUNT_WIDTH-1:0] best_count
);

    localparam int unsigned TimerMax   = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES
                                                                        : DRAIN_CYCLES;
    localparam int unsigned TimerWidth = $clog2(TimerMax + 1);

    localparam logic [TimerWidth-1:0]  SettleLast = TimerWidth'(SETTLE_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  DrainLast  = TimerWidth'(DRAIN_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] MinCount   = COUNT_WIDTH'(MIN_COUNT);

    scan_state_e            state_q, state_d;
    logic [TimerWidth-1:0]  timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             color_q, color_d;
    logic [1:0]             scan_q, scan_d;
    logic                   auto_q, auto_d;
    logic [COUNT_WIDTH-1:0] tab_r_q, tab_r_d;
    logic [COUNT_WIDTH-1:0] tab_g_q, tab_g_d;
    logic                   result_valid_q, result_valid_d;
    logic [1:0]             result_color_q, result_color_d;
    logic [COUNT_WIDTH-1:0] result_count_q, result_count_d;
    logic                   best_valid_q, best_valid_d;
    logic [1:0]             best_color_q, best_color_d;
    logic [COUNT_WIDTH-1:0] best_count_q, best_count_d;

    logic                   hit;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic [1:0]             scan_next;
    logic [1:0]             start_base;
    logic [1:0]             start_scan;
    logic [1:0]             start_color;
    logic [1:0]             max_idx;
    logic [COUNT_WIDTH-1:0] max_val;

    assign hit       = trk_valid & trk_is_target;
    assign count_inc = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
    assign scan_next = next_color(scan_q);

    // A frame started from REPORT sees the scan index the report is about to advance to.
    // Entering auto mode from fixed mode restarts the scan at red.
    always_comb begin
        start_base = (state_q == StReport && auto_q) ? scan_next : scan_q;
        if (scan_mode) begin
            start_scan  = auto_q ? start_base : ColorR;
            start_color = start_scan;
        end else begin
            start_scan  = start_base;
            start_color = (fixed_color == 2'b11) ? ColorR : fixed_color;
        end
    end

    // Blue is reported straight from the live count, so only R and G need table storage.
    color_max_select #(
        .WIDTH(COUNT_WIDTH)
    ) u_max_select (
        .count_r(tab_r_q),
        .count_g(tab_g_q),
        .count_b(count_q),
        .max_idx(max_idx),
        .max_val(max_val)
    );

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        count_d        = count_q;
        color_d        = color_q;
        scan_d         = scan_q;
        auto_d         = auto_q;
        tab_r_d        = tab_r_q;
        tab_g_d        = tab_g_q;
        result_valid_d = 1'b0;
        result_color_d = result_color_q;
        result_count_d = result_count_q;
        best_valid_d   = best_valid_q;
        best_color_d   = best_color_q;
        best_count_d   = best_count_q;

        if (!enable) begin
            state_d = StIdle;
            timer_d = '0;
            count_d = '0;
            scan_d  = ColorR;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        state_d = StSettle;
                        timer_d = '0;
                        count_d = '0;
                        color_d = start_color;
                        scan_d  = start_scan;
                        auto_d  = scan_mode;
                    end
                end
                StSettle: begin
                    if (frame_start) begin
                        timer_d = '0;
                        count_d = '0;
                    end else if (timer_q == SettleLast) begin
                        state_d = StActive;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TimerWidth'(1);
                    end
                end
                StActive: begin
                    if (frame_start) begin
                        state_d = StSettle;
                        timer_d = '0;
                        count_d = '0;
                    end else begin
                        if (hit) count_d = count_inc;
                        if (frame_end) begin
                            state_d = StDrain;
                            timer_d = '0;
                        end
                    end
                end
                StDrain: begin
                    if (frame_start) begin
                        state_d = StSettle;
                        timer_d = '0;
                        count_d = '0;
                    end else begin
                        if (hit) count_d = count_inc;
                        if (timer_q == DrainLast) begin
                            state_d        = StReport;
                            result_valid_d = 1'b1;
                            result_color_d = color_q;
                            result_count_d = count_d;
                        end else begin
                            timer_d = timer_q + TimerWidth'(1);
                        end
                    end
                end
                StReport: begin
                    if (auto_q) begin
                        scan_d = scan_next;
                        if (color_q == ColorR) tab_r_d = count_q;
                        if (color_q == ColorG) tab_g_d = count_q;
                        if (color_q == ColorB) begin
                            best_color_d = max_idx;
                            best_count_d = max_val;
                            best_valid_d = (max_val >= MinCount);
                        end
                    end
                    state_d = StIdle;
                    if (frame_start) begin
                        state_d = StSettle;
                        timer_d = '0;
                        count_d = '0;
                        color_d = start_color;
                        scan_d  = start_scan;
                        auto_d  = scan_mode;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            count_q        <= '0;
            color_q        <= ColorR;
            scan_q         <= ColorR;
            auto_q         <= 1'b0;
            tab_r_q        <= '0;
            tab_g_q        <= '0;
            result_valid_q <= 1'b0;
            result_color_q <= ColorR;
            result_count_q <= '0;
            best_valid_q   <= 1'b0;
            best_color_q   <= ColorR;
            best_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            count_q        <= count_d;
            color_q        <= color_d;
            scan_q         <= scan_d;
            auto_q         <= auto_d;
            tab_r_q        <= tab_r_d;
            tab_g_q        <= tab_g_d;
            result_valid_q <= result_valid_d;
            result_color_q <= result_color_d;
            result_count_q <= result_count_d;
            best_valid_q   <= best_valid_d;
            best_color_q   <= best_color_d;
            best_count_q   <= best_count_d;
        end
    end

    assign color_select = color_q;
    assign busy         = (state_q != StIdle);
    assign result_valid = result_valid_q;
    assign result_color = result_color_q;
    assign result_count = result_count_q;
    assign best_valid   = best_valid_q;
    assign best_color   = best_color_q;
    assign best_count   = best_count_q;

endmodule
